// File: rtl/fp2_inv.sv
// fp2_inv: Fp2 inverse over p = 5*2^248-1 via Fermat exponentiation on one pipelined fp_mul.
module fp_mul #(
    parameter int L = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [254:0] x,
    input  logic [254:0] y,
    output logic [254:0] q,
    output logic         v
);
    localparam logic [509:0] P = (510'(5) << 248) - 510'(1);
    logic [254:0] pp [L];
    logic [L-1:0] vv;
    logic [509:0] full;
    assign full = {255'd0, x} * {255'd0, y};
    always_ff @(posedge clk) begin
        pp[0] <= 255'(full % P);
        for (int i = 1; i < L; i++) pp[i] <= pp[i-1];
        if (rst) vv <= '0;
        else begin
            vv[0] <= go;
            for (int i = 1; i < L; i++) vv[i] <= vv[i-1];
        end
    end
    assign q = pp[L-1];
    assign v = vv[L-1];
endmodule

module fp2_inv #(
    parameter int LATENCY_FP_MUL = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] y_re,
    input  logic [254:0] y_im,
    output logic         busy,
    output logic         done,
    output logic [254:0] x_re,
    output logic [254:0] x_im
);
    localparam int L = LATENCY_FP_MUL;
    localparam int LATENCY_FP2_INV = 499 * L + 5;
    localparam int CW = $clog2(LATENCY_FP2_INV + 1);
    localparam logic [254:0] P = (255'(5) << 248) - 255'(1);
    localparam logic [254:0] E = P - 255'(2);
    typedef enum logic [1:0] {IDLE, NORM, EXP, FIN} state_t;
    state_t state, state_n;
    logic [254:0] a, b, n, t, r0, r1, q, mx, my, n_sum;
    logic [255:0] sum;
    logic [CW-1:0] cnt;
    logic [7:0] bit_idx;
    logic sq, go, v, norm_end, fin_end, exp_end, mul_n;
    fp_mul #(.L(L)) u_mul (.clk(clk), .rst(rst), .go(go), .x(mx), .y(my), .q(q), .v(v));
    assign sum = {1'b0, r0} + {1'b0, r1};
    assign n_sum = sum >= {1'b0, P} ? 255'(sum - {1'b0, P}) : sum[254:0];
    assign norm_end = state == NORM && cnt == CW'(L + 2);
    assign fin_end = state == FIN && cnt == CW'(L + 1);
    assign mul_n = sq && E[bit_idx];
    // a completed square on a clear bit 0 (or the final multiply) ends the walk
    assign exp_end = state == EXP && v && !mul_n && bit_idx == 8'd0;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        go = 1'b0;
        mx = q;
        my = q;
        case (state)
            IDLE: state_n = start ? NORM : IDLE;
            NORM: begin
                go = cnt < CW'(2) || norm_end;
                mx = cnt == CW'(0) ? a : cnt == CW'(1) ? b : n_sum;
                my = mx;
                state_n = norm_end ? EXP : NORM;
            end
            EXP: begin
                go = v;
                mx = exp_end ? a : q;
                my = mul_n ? n : q;
                state_n = exp_end ? FIN : EXP;
            end
            FIN: begin
                go = cnt == CW'(0);
                mx = b;
                my = t;
                state_n = fin_end ? IDLE : FIN;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            x_re <= '0;
            x_im <= '0;
            cnt <= '0;
            bit_idx <= 8'd249;
            sq <= 1'b1;
        end else begin
            busy <= state != IDLE;
            done <= fin_end;
            cnt <= state_n != state ? '0 : cnt + CW'(1);
            if (state == IDLE && start) begin
                a <= y_re;
                b <= y_im;
            end
            if (v) begin
                r0 <= r1;
                r1 <= q;
            end
            if (norm_end) begin
                n <= n_sum;
                bit_idx <= 8'd249;
                sq <= 1'b1;
            end
            if (state == EXP && v) begin
                t <= q;
                sq <= !mul_n;
                if (!mul_n && bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
            end
            if (fin_end) begin
                x_re <= r0;
                x_im <= r1 == '0 ? '0 : P - r1;
            end
        end
    end
endmodule

// File: tb/tb_fp2_inv.sv
// tb_fp2_inv: randomized Fp2 inversion checks against an arithmetic reference and fp2_mul round trip.
module tb_fp2_inv;
    localparam int L = 5;
    localparam int LAT = 499 * L + 5;
    localparam logic [254:0] P = (255'(5) << 248) - 255'(1);
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [254:0] y_re = '0, y_im = '0, x_re, x_im;
    logic busy, done;
    int checks = 0, errors = 0;

    fp2_inv #(.LATENCY_FP_MUL(L)) dut (.clk(clk), .rst(rst), .start(start), .y_re(y_re), .y_im(y_im),
        .busy(busy), .done(done), .x_re(x_re), .x_im(x_im));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] mm(input logic [254:0] x, input logic [254:0] y);
        logic [509:0] f;
        f = {255'd0, x} * {255'd0, y};
        return 255'(f % {255'd0, P});
    endfunction

    function automatic logic [254:0] ad(input logic [254:0] x, input logic [254:0] y);
        logic [255:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s >= {1'b0, P} ? 255'(s - {1'b0, P}) : s[254:0];
    endfunction

    function automatic logic [254:0] ng(input logic [254:0] x);
        return x == '0 ? '0 : P - x;
    endfunction

    function automatic logic [254:0] pw(input logic [254:0] base, input logic [254:0] e);
        logic [254:0] r;
        r = 255'd1;
        for (int i = 0; i < 255; i++) begin
            if (e[i]) r = mm(r, base);
            base = mm(base, base);
        end
        return r;
    endfunction

    function automatic logic [254:0] rnd();
        logic [254:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[222:0], 32'($urandom())};
        r[254:251] = 4'd0;
        return r >= P ? r - P : r;
    endfunction

    task automatic ref_inv(input logic [254:0] ya, input logic [254:0] yb, output logic [254:0] ea, output logic [254:0] eb);
        logic [254:0] t;
        t = pw(ad(mm(ya, ya), mm(yb, yb)), P - 255'(2));
        ea = mm(ya, t);
        eb = ng(mm(yb, t));
    endtask

    task automatic run(input logic [254:0] ya, input logic [254:0] yb, input int poke,
                       output logic [254:0] ra, output logic [254:0] rb);
        int n;
        @(negedge clk);
        y_re = ya;
        y_im = yb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        y_re = rnd();
        y_im = rnd();
        n = 0;
        while (!done && n < LAT + 50) begin
            @(posedge clk);
            #1;
            n++;
            start = n == poke;
        end
        start = 1'b0;
        chk("latency", 255'(n), 255'(LAT));
        chk("busy_at_done", 255'(busy), 255'd1);
        ra = x_re;
        rb = x_im;
        @(posedge clk);
        #1;
        chk("done_pulse", 255'(done), 255'd0);
        chk("busy_after", 255'(busy), 255'd0);
    endtask

    initial begin
        logic [254:0] ra, rb, ea, eb, pa[4], pb[4];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 255'(busy), 255'd0);
        chk("rst_done", 255'(done), 255'd0);
        chk("rst_x_re", x_re, '0);
        chk("rst_x_im", x_im, '0);
        rst = 1'b0;

        run(255'd1, 255'd0, -1, ra, rb);
        chk("one_re", ra, 255'd1);
        chk("one_im", rb, '0);
        run(255'd0, 255'd1, -1, ra, rb);
        chk("i_re", ra, '0);
        chk("i_im", rb, P - 255'd1);
        run(255'd2, 255'd0, -1, ra, rb);
        chk("two_re", ra, (P >> 1) + 255'd1);
        chk("two_im", rb, '0);
        run(255'd0, 255'd0, -1, ra, rb);
        chk("zero_re", ra, '0);
        chk("zero_im", rb, '0);

        pa[0] = P - 255'd1; pb[0] = rnd();
        pa[1] = rnd(); pa[1][251:220] = 32'h3807ed85;
        pb[1] = rnd(); pb[1][251:220] = 32'h127ba047;
        pa[2] = rnd(); pb[2] = rnd();
        pa[3] = rnd(); pb[3] = P - 255'd1;
        for (int k = 0; k < 4; k++) begin
            run(pa[k], pb[k], k == 3 ? LAT - 1 : 300 + 500 * k, ra, rb);
            ref_inv(pa[k], pb[k], ea, eb);
            chk("ref_re", ra, ea);
            chk("ref_im", rb, eb);
            chk("trip_re", ad(mm(ra, pa[k]), ng(mm(rb, pb[k]))), 255'd1);
            chk("trip_im", ad(mm(ra, pb[k]), mm(rb, pa[k])), '0);
        end

        @(negedge clk);
        y_re = 255'd3;
        y_im = 255'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (999) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 255'(busy), 255'd0);
        chk("mid_rst_done", 255'(done), 255'd0);
        chk("mid_rst_x_re", x_re, '0);
        chk("mid_rst_x_im", x_im, '0);
        run(255'd1, 255'd0, -1, ra, rb);
        chk("restart_re", ra, 255'd1);
        chk("restart_im", rb, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp2_inv.md
# fp2_inv

Sequential Fp2 inverter for the SQIsign level-1 field, p = 5·2^248 − 1, where Fp2 = Fp[i]/(i²+1). It computes x = 1/y = (y_re − i·y_im)/(y_re² + y_im²). The Fp inversion uses Fermat exponentiation, n^(p−2), driven by a fixed square-and-multiply FSM over one internal pipelined fp_mul. It sits next to fp2_mul in the arithmetic datapath and undoes a multiplication: fp2_mul(z, fp2_inv(z)) = 1.

## Interface
- LATENCY_FP_MUL, default 5: latency in cycles of the instantiated fp_mul, from operands in to product out.
- LATENCY_FP2_INV, default 499·LATENCY_FP_MUL+5: cycles from start acceptance to done. Derived, localparam.
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request. Sampled only in IDLE.
- y_re, input, 255: real part of operand. Must be < p. Captured on start acceptance.
- y_im, input, 255: imaginary part of operand. Must be < p. Captured on start acceptance.
- busy, output, 1: high from the cycle after acceptance through the done cycle.
- done, output, 1: one-cycle pulse; x_re/x_im are valid in that cycle.
- x_re, output, 255: real part of the result, canonical (< p). Held until the next done or reset.
- x_im, output, 255: imaginary part of the result, canonical (< p). Held until the next done or reset.

## Operation
- States: IDLE → NORM → EXP → FIN → IDLE.
- IDLE: when start=1, latch y_re/y_im into internal registers a/b and go to NORM. Inputs are ignored afterwards.
- NORM:
  - Issue a·a, then b·b on the next cycle (the multiplier is pipelined).
  - When both products are back, register n = (a² + b²) mod p with a single conditional subtract.
  - Load t = n. This corresponds to exponent bit 250.
- EXP: walk the constant e = p−2 = 0x4ff…fd (251 bits) from bit 249 down to bit 0.
  - Every bit: t = t·t.
  - Bit = 1: also t = t·n.
  - Exactly 250 squarings and 247 multiplies, i.e. 497 dependent ops with no early exit.
  - The exponent is a hard-coded constant, and a bit counter 249…0 drives the walk.
- FIN:
  - Issue a·t, then b·t on the next cycle.
  - x_re = a·t.
  - x_im = (p − b·t) when b·t ≠ 0, else 0.
  - Register both, pulse done, return to IDLE.
- Zero operand: n = 0 gives t = 0, so the output is (0, 0). This is no error and needs no special path.
- start while busy: ignored, with no queueing.
- All modular add/sub results are reduced to < p before being registered.

## Timing
- Reset values: busy=0, done=0, x_re=0, x_im=0. State=IDLE, bit counter=249.
- Cycle numbering: cycle 0 is the edge where start is sampled in IDLE.
- Cycles 1 and 2: a² and b² issued.
- Cycle 3+L: n registered, where L = LATENCY_FP_MUL.
- EXP op k (0…496): issued at 3+L+k·L; result captured at 3+L+(k+1)·L.
- Cycles 3+498L and 4+498L: a·t and b·t issued. Products captured at 3+499L and 4+499L.
- Cycle 5+499L: x_re, x_im and done are updated together. This equals LATENCY_FP2_INV, i.e. 2500 cycles at L=5.
- busy: high in cycles 1…5+499L, low from the next cycle.
- start in the done cycle is ignored, because the state is not yet IDLE. start on the following cycle is accepted.
- rst mid-operation: on the next edge, return to IDLE with all outputs zero. Any in-flight fp_mul results are discarded; the pipeline valid/tag bits are cleared.
- Back-to-back operations: minimum spacing is LATENCY_FP2_INV+1 cycles.

## Test plan
- y=(1,0): start → at cycle 5+499L, done=1 with x=(1,0); busy falls on the next cycle.
- y=(0,1): expected x=(0, p−1), since 1/i = −i.
  - x_im = 0x4ffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffe.
- y=(2,0): expected x=((p+1)/2, 0) = (0x28 followed by 61 hex zeros, 0).
- y=(0,0): expected x=(0,0), with done at the nominal cycle.
- Round trip, four operand pairs:
  - Each pair: y_re, y_im < p, including p−1 and 0x3807ed85…, 0x127ba047….
  - Feed fp2_inv(y) and y into fp2_mul; the product must equal (1,0).
  - Also check start pulses issued while busy are ignored.
- Reset and restart:
  - Assert rst for one cycle at cycle 1000: outputs read 0 and busy=0 on the next cycle.
  - Then start with y=(1,0): it must complete normally at 5+499L after the new start, with x=(1,0).
